// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one 16-bit word per instruction from
// instruction memory, holds it for the control decoder, and computes the
// next PC, either sequential or redirected by jump or taken branch.
module fetch_unit #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [11:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  input  logic        jump,
  input  logic        branch,
  input  logic        acc_zero,
  input  logic        stall,
  output logic [3:0]  op,
  output logic [11:0] imm,
  output logic        valid,
  output logic [11:0] pc_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [11:0] pc_reg, pc_next;
  logic [15:0] ir_reg, ir_next;
  logic [11:0] pc_out_reg, pc_out_next;

  // Redirect target is always the immediate field of the held instruction.
  logic [11:0] target;
  assign target = ir_reg[11:0];

  // State register; reset takes effect immediately so a pending request drops at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      pc_reg     <= RESET_PC;
      ir_reg     <= 16'h0000;
      pc_out_reg <= RESET_PC;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      ir_reg     <= ir_next;
      pc_out_reg <= pc_out_next;
    end
  end

  // Next-state and next-PC selection; everything holds unless a transition fires.
  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    ir_next     = ir_reg;
    pc_out_next = pc_out_reg;
    case (state_reg)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        // Wait for memory; data is captured on the same edge as the ack.
        if (imem_ack) begin
          ir_next     = imem_data;
          pc_out_next = pc_reg;
          state_next  = ISSUE;
        end
      end
      ISSUE: begin
        // Control inputs only matter on the edge that leaves ISSUE.
        if (!stall) begin
          if (jump) begin
            pc_next = target;
          end else if (branch && acc_zero) begin
            pc_next = target;
          end else begin
            pc_next = pc_reg + 12'd1;
          end
          state_next = FETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are decoded from registered state, so they never glitch on inputs.
  assign imem_req  = (state_reg == FETCH);
  assign imem_addr = pc_reg;
  assign valid     = (state_reg == ISSUE);
  assign op        = valid ? ir_reg[15:12] : 4'b0000;
  assign imm       = valid ? ir_reg[11:0]  : 12'h000;
  assign pc_out    = pc_out_reg;

endmodule
